// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: frame-request handshake between a producer (master) and the UART transmitter (slave)
// Signals: tx_valid (frame request), tx_ready (transmitter idle), tx_data (payload, LSB first),
//          parity_odd (1 = odd parity; present only with UART_TX_PARITY_EN)
interface uart_tx_sequencer_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
`ifdef UART_TX_PARITY_EN
    logic                 parity_odd;
    modport master (output tx_valid, tx_data, parity_odd, input tx_ready);
    modport slave  (input tx_valid, tx_data, parity_odd, output tx_ready);
`else
    modport master (output tx_valid, tx_data, input tx_ready);
    modport slave  (input tx_valid, tx_data, output tx_ready);
`endif
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: baud-tick paced UART frame serializer (start, DATA_BITS LSB first, optional parity, STOP_BITS stops)
// Ports: fsm_clk (clock), rst_n (async active-low reset), baud_tick (one-cycle bit-period strobe),
//        bus (uart_tx_sequencer_if.slave: tx_valid/tx_data/parity_odd in, registered tx_ready out),
//        txd (registered serial line, idle high), busy (not IDLE), done (one-cycle pulse at frame end)
// Optional parity bit and parity_odd input are compiled in with macro UART_TX_PARITY_EN.
module uart_tx_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic               fsm_clk,
    input  logic               rst_n,
    input  logic               baud_tick,
    uart_tx_sequencer_if.slave bus,
    output logic               txd,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_sequencer: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_sequencer: STOP_BITS must be 1..2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 txd_n, done_n, ready_n, accept;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    assign accept = bus.tx_valid && bus.tx_ready;
    assign busy   = state != IDLE;

    // Payload is latched into a shift register so later tx_data changes cannot reach the frame in flight.
    // The parity bit is resolved at acceptance, which fixes both the data and parity_odd used for it.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        sh_n       = sh;
        txd_n      = txd;
        done_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n      = par;
`endif
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (accept) begin
                    state_n = ARM;
                    sh_n    = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^bus.tx_data ^ bus.parity_odd;
`endif
                end
            end
            ARM: if (baud_tick) begin
                state_n = START;
                txd_n   = 1'b0;
            end
            START: if (baud_tick) begin
                state_n   = DATA;
                txd_n     = sh[0];
                sh_n      = sh >> 1;
                bit_cnt_n = '0;
            end
            DATA: if (baud_tick) begin
                if (bit_cnt == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_n    = PARITY;
                    txd_n      = par;
`else
                    state_n    = STOP;
                    txd_n      = 1'b1;
                    stop_cnt_n = 1'b0;
`endif
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    txd_n     = sh[0];
                    sh_n      = sh >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_tick) begin
                state_n    = STOP;
                txd_n      = 1'b1;
                stop_cnt_n = 1'b0;
            end
`endif
            STOP: if (baud_tick) begin
                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    stop_cnt_n = stop_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
        // Registered ready tracks the next state, so it is high in the very cycle IDLE is entered.
        ready_n = state_n == IDLE;
    end

    always_ff @(posedge fsm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            sh           <= '0;
            txd          <= 1'b1;
            done         <= 1'b0;
            bus.tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            stop_cnt     <= stop_cnt_n;
            sh           <= sh_n;
            txd          <= txd_n;
            done         <= done_n;
            bus.tx_ready <= ready_n;
`ifdef UART_TX_PARITY_EN
            par          <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: directed self-checking bench for uart_tx_sequencer (8N1-style and 5-bit/2-stop instances)
module tb_uart_tx_sequencer;
    logic fsm_clk = 1'b0;
    logic rst_n = 1'b0;
    logic baud_tick = 1'b0;
    logic a_txd, a_busy, a_done, b_txd, b_busy, b_done;
    int tests = 0;
    int fails = 0;

`ifdef UART_TX_PARITY_EN
    localparam int NA = 11;
    localparam int NB = 9;
    localparam logic [10:0] EXP55 = 11'b10010101010;
    localparam logic [10:0] EXP3C = 11'b10001111000;
    localparam logic [10:0] EXPA3 = 11'b10101000110;
    localparam logic [10:0] EXP1F = 11'b11111111110;
`else
    localparam int NA = 10;
    localparam int NB = 8;
    localparam logic [10:0] EXP55 = 11'b01010101010;
    localparam logic [10:0] EXP3C = 11'b01001111000;
    localparam logic [10:0] EXPA3 = 11'b01101000110;
    localparam logic [10:0] EXP1F = 11'b00011111110;
`endif

    uart_tx_sequencer_if #(.DATA_BITS(8)) a_if ();
    uart_tx_sequencer_if #(.DATA_BITS(5)) b_if ();

    uart_tx_sequencer #(.DATA_BITS(8), .STOP_BITS(1)) u_a (
        .fsm_clk(fsm_clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(a_if),
        .txd(a_txd), .busy(a_busy), .done(a_done)
    );
    uart_tx_sequencer #(.DATA_BITS(5), .STOP_BITS(2)) u_b (
        .fsm_clk(fsm_clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(b_if),
        .txd(b_txd), .busy(b_busy), .done(b_done)
    );

    always #5 fsm_clk = ~fsm_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t);
        baud_tick = t;
        @(negedge fsm_clk);
        baud_tick = 1'b0;
    endtask

    task automatic tick4();
        repeat (3) step(1'b0);
        step(1'b1);
    endtask

    // Request a frame; the acceptance cycle carries a baud_tick that must not count.
    task automatic accept(input bit sel, input logic [7:0] d, input bit hold);
        if (sel) begin
            b_if.tx_data  = d[4:0];
            b_if.tx_valid = 1'b1;
        end else begin
            a_if.tx_data  = d;
            a_if.tx_valid = 1'b1;
        end
        step(1'b1);
        if (!hold) begin
            a_if.tx_valid = 1'b0;
            b_if.tx_valid = 1'b0;
        end
    endtask

    task automatic frame(input string tag, input bit sel, input logic [10:0] exp, input int n,
                         input int chg, input logic [7:0] nd);
        for (int i = 0; i < n; i++) begin
            tick4();
            if (i == chg) a_if.tx_data = nd;
            chk($sformatf("%s_bit%0d", tag, i), sel ? b_txd : a_txd, exp[i]);
            chk($sformatf("%s_nodone%0d", tag, i), sel ? b_done : a_done, 1'b0);
            chk($sformatf("%s_busy%0d", tag, i), sel ? b_busy : a_busy, 1'b1);
        end
        tick4();
        chk($sformatf("%s_done", tag), sel ? b_done : a_done, 1'b1);
        chk($sformatf("%s_end_txd", tag), sel ? b_txd : a_txd, 1'b1);
        chk($sformatf("%s_end_busy", tag), sel ? b_busy : a_busy, 1'b0);
        chk($sformatf("%s_end_ready", tag), sel ? b_if.tx_ready : a_if.tx_ready, 1'b1);
    endtask

    initial begin
        a_if.tx_valid = 1'b0;
        a_if.tx_data  = '0;
        b_if.tx_valid = 1'b0;
        b_if.tx_data  = '0;
`ifdef UART_TX_PARITY_EN
        a_if.parity_odd = 1'b0;
        b_if.parity_odd = 1'b0;
`endif
        repeat (2) @(negedge fsm_clk);
        chk("rst_txd", a_txd, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_ready", a_if.tx_ready, 1'b0);
        chk("rst_b_ready", b_if.tx_ready, 1'b0);
        rst_n = 1'b1;
        chk("ready_before_edge", a_if.tx_ready, 1'b0);
        step(1'b0);
        chk("ready_after_release", a_if.tx_ready, 1'b1);
        chk("b_ready_after_release", b_if.tx_ready, 1'b1);

        accept(1'b0, 8'h55, 1'b0);
        chk("arm_txd", a_txd, 1'b1);
        chk("arm_busy", a_busy, 1'b1);
        chk("arm_ready", a_if.tx_ready, 1'b0);
        repeat (3) step(1'b0);
        chk("arm_hold_txd", a_txd, 1'b1);
        chk("arm_hold_busy", a_busy, 1'b1);
        frame("f55", 1'b0, EXP55, NA, 3, 8'hFF);
        step(1'b0);
        chk("f55_done_clear", a_done, 1'b0);
        chk("f55_idle_ready", a_if.tx_ready, 1'b1);

        accept(1'b0, 8'h55, 1'b0);
        repeat (5) tick4();
        chk("pre_rst_bit3", a_txd, 1'b0);
        chk("pre_rst_busy", a_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_txd", a_txd, 1'b1);
        chk("midrst_busy", a_busy, 1'b0);
        chk("midrst_done", a_done, 1'b0);
        chk("midrst_ready", a_if.tx_ready, 1'b0);
        @(negedge fsm_clk);
        rst_n = 1'b1;
        chk("rel_ready_before_edge", a_if.tx_ready, 1'b0);
        step(1'b0);
        chk("rel_ready", a_if.tx_ready, 1'b1);
        chk("rel_txd", a_txd, 1'b1);

        accept(1'b0, 8'h3C, 1'b1);
        frame("f3c", 1'b0, EXP3C, NA, 2, 8'hA3);
        step(1'b0);
        chk("b2b_busy", a_busy, 1'b1);
        chk("b2b_ready", a_if.tx_ready, 1'b0);
        chk("b2b_done", a_done, 1'b0);
        a_if.tx_valid = 1'b0;
        frame("fa3", 1'b0, EXPA3, NA, -1, 8'h00);
        step(1'b0);
        chk("fa3_done_clear", a_done, 1'b0);

`ifdef UART_TX_PARITY_EN
        a_if.parity_odd = 1'b0;
        accept(1'b0, 8'h07, 1'b0);
        frame("f07_even", 1'b0, 11'b11000001110, NA, -1, 8'h00);
        a_if.parity_odd = 1'b1;
        accept(1'b0, 8'h07, 1'b0);
        a_if.parity_odd = 1'b0;
        frame("f07_odd", 1'b0, 11'b10000001110, NA, -1, 8'h00);
`endif

        accept(1'b1, 8'h1F, 1'b0);
        chk("b_arm_busy", b_busy, 1'b1);
        frame("f1f", 1'b1, EXP1F, NB, -1, 8'h00);
        step(1'b0);
        chk("f1f_done_clear", b_done, 1'b0);
        chk("a_idle_during_b", a_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
